dummy_sm_driver: RTL and testbench

Initiator-side controller for the 4-state trigger-driven handshake state machine (IDLE=0, RUN=1, WAIT=2, DONE=3).
- Queues start requests from upstream and issues single-cycle trigger pulses to the responder only when it is IDLE.
- Tracks the responder's 2-bit state through RUN, WAIT, DONE and back to IDLE.
- Counts completed transactions and flags sequence violations and timeouts.

---
 rtl/dummy_sm_driver.sv | 177 +++++++++++++++++
 tb/tb_dummy_sm_driver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dummy_sm_driver.sv
// Initiator-side driver for the 4-state trigger handshake (IDLE, RUN, WAIT, DONE).
// Queues start requests, fires one-cycle triggers at an idle responder, follows
// the responder through its sequence, counts completions and flags violations.
module dummy_sm_driver #(
  parameter int unsigned MAX_PEND = 3,
  parameter int unsigned TIMEOUT  = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_req,
  input  logic                          clr_err,
  input  logic [1:0]                    sm_state,
  output logic                          trigger,
  output logic                          busy,
  output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt,
  output logic                          req_drop,
  output logic                          done_pulse,
  output logic [CNT_W-1:0]              done_cnt,
  output logic                          err_seq,
  output logic                          err_timeout
);

  localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);
  localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT);

  localparam logic [1:0] SM_IDLE = 2'd0;
  localparam logic [1:0] SM_RUN  = 2'd1;
  localparam logic [1:0] SM_DONE = 2'd3;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_ARM   = 2'd1,
    D_TRACK = 2'd2
  } drv_state_t;

  drv_state_t      r_state;
  logic [1:0]      r_exp;
  logic [WD_W-1:0] r_wd;

  logic       w_active;
  logic       w_issue;
  logic       w_full;
  logic       w_inc;
  logic       w_drop;
  logic [1:0] w_prev;
  logic       w_match;
  logic       w_stall;
  logic       w_seq_err;
  logic       w_retire;
  logic       w_to_err;
  logic       w_abort;
  logic       w_done;

  // Decode of the current cycle: issue, queue, sequence and watchdog events.
  always_comb begin
    w_active  = (r_state != D_IDLE);
    w_issue   = (r_state == D_IDLE) && (pend_cnt != '0) && (sm_state == SM_IDLE);
    w_full    = (pend_cnt == PEND_MAX);
    // A full queue still accepts a request when a trigger frees a slot this cycle.
    w_drop    = start_req && w_full && !w_issue;
    w_inc     = start_req && !w_drop;
    // The state before exp wraps naturally in 2 bits: RUN->IDLE, IDLE->DONE.
    w_prev    = r_exp - 2'd1;
    w_match   = (sm_state == r_exp);
    w_stall   = (sm_state == w_prev);
    w_seq_err = ((r_state == D_ARM) && (sm_state != SM_IDLE)) ||
                ((r_state == D_TRACK) && !w_match && !w_stall);
    w_retire  = (r_state == D_TRACK) && w_match && (r_exp == SM_IDLE);
    // Retirement on the limit cycle still counts as success.
    w_to_err  = w_active && (r_wd >= WD_LIMIT) && !w_retire;
    w_abort   = w_seq_err || w_to_err;
    w_done    = (r_state == D_TRACK) && w_match && (r_exp == SM_DONE) && !w_abort;
  end

  // Pending request counter and queue-full drop pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_cnt <= '0;
      req_drop <= 1'b0;
    end else begin
      req_drop <= w_drop;
      if (w_inc && !w_issue) begin
        pend_cnt <= pend_cnt + PEND_W'(1);
      end else if (!w_inc && w_issue) begin
        pend_cnt <= pend_cnt - PEND_W'(1);
      end
    end
  end

  // Sticky error flags; a fresh error beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_seq     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_seq     <= (err_seq     && !clr_err) || w_seq_err;
      err_timeout <= (err_timeout && !clr_err) || w_to_err;
    end
  end

  // Driver FSM: trigger issue, responder tracking, watchdog, completion count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= D_IDLE;
      r_exp      <= SM_IDLE;
      r_wd       <= '0;
      trigger    <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      done_cnt   <= '0;
    end else begin
      done_pulse <= 1'b0;
      case (r_state)
        D_IDLE: begin
          if (w_issue) begin
            trigger <= 1'b1;
            busy    <= 1'b1;
            r_wd    <= WD_W'(1);
            r_exp   <= SM_RUN;
            r_state <= D_ARM;
          end else begin
            trigger <= 1'b0;
          end
        end

        D_ARM: begin
          trigger <= 1'b0;
          if (w_abort) begin
            busy    <= 1'b0;
            r_wd    <= '0;
            r_exp   <= SM_IDLE;
            r_state <= D_IDLE;
          end else begin
            r_wd    <= r_wd + WD_W'(1);
            r_state <= D_TRACK;
          end
        end

        D_TRACK: begin
          trigger <= 1'b0;
          if (w_abort) begin
            busy    <= 1'b0;
            r_wd    <= '0;
            r_exp   <= SM_IDLE;
            r_state <= D_IDLE;
          end else if (w_retire) begin
            busy    <= 1'b0;
            r_wd    <= '0;
            r_state <= D_IDLE;
          end else begin
            r_wd <= r_wd + WD_W'(1);
            if (w_match) begin
              r_exp <= r_exp + 2'd1;
            end
            if (w_done) begin
              done_pulse <= 1'b1;
              done_cnt   <= done_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          trigger <= 1'b0;
          busy    <= 1'b0;
          r_wd    <= '0;
          r_exp   <= SM_IDLE;
          r_state <= D_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dummy_sm_driver.sv
// Bench for dummy_sm_driver: behavioural responder, scoreboard of expected
// completions and errors, checked as the DUT reports them.
module tb_dummy_sm_driver;

  localparam int unsigned MAX_PEND = 3;
  localparam int unsigned TIMEOUT  = 8;
  localparam int unsigned CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_req;
  logic             clr_err;
  logic [1:0]       sm_state;
  logic             trigger;
  logic             busy;
  logic [1:0]       pend_cnt;
  logic             req_drop;
  logic             done_pulse;
  logic [CNT_W-1:0] done_cnt;
  logic             err_seq;
  logic             err_timeout;

  dummy_sm_driver #(.MAX_PEND(MAX_PEND), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start_req(start_req), .clr_err(clr_err),
    .sm_state(sm_state), .trigger(trigger), .busy(busy), .pend_cnt(pend_cnt),
    .req_drop(req_drop), .done_pulse(done_pulse), .done_cnt(done_cnt),
    .err_seq(err_seq), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] cnt; int lat; int gap; } done_t;
  typedef struct { int kind; int lat; } err_t;   // kind 1 = sequence, 2 = timeout

  done_t q_done[$];
  err_t  q_err[$];
  logic [7:0] exp_cnt = 8'd0;
  int exp_drop = 0;
  int n_drop_obs = 0;
  int n_trig = 0;
  int n_chk = 0;
  int n_pass = 0;

  int wait_extra = 0;
  bit jump_once = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic push_done(input int lat, input int gap);
    done_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.cnt = exp_cnt; e.lat = lat; e.gap = gap;
    q_done.push_back(e);
  endtask

  task automatic push_err(input int kind, input int lat);
    err_t e;
    e.kind = kind; e.lat = lat;
    q_err.push_back(e);
  endtask

  task automatic pulse(input int n);
    start_req = 1'b1;
    repeat (n) @(negedge clk);
    start_req = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while ((busy || pend_cnt != 2'd0 || sm_state != 2'd0) && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle_in_budget", 32'(k < max), 32'd1);
    @(negedge clk);
  endtask

  // Responder: IDLE -trigger-> RUN -> WAIT (optionally held) -> DONE -> IDLE.
  initial begin
    logic [1:0] nxt;
    int hold = 0;
    sm_state = 2'd0;
    forever begin
      @(negedge clk);
      case (sm_state)
        2'd0: nxt = trigger ? 2'd1 : 2'd0;
        2'd1: begin
          if (jump_once) begin nxt = 2'd3; jump_once = 1'b0; end
          else nxt = 2'd2;
        end
        2'd2: begin
          if (hold < wait_extra) begin hold++; nxt = 2'd2; end
          else begin hold = 0; nxt = 2'd3; end
        end
        default: nxt = 2'd0;
      endcase
      @(posedge clk);
      #1 sm_state = nxt;
    end
  end

  // Monitor: pops the scoreboard on completions and error onsets.
  initial begin
    bit prev_trig = 0, prev_seq = 0, prev_to = 0, busy_chk = 0;
    int trig_cyc = 0, last_done = 0;
    done_t d;
    err_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_trig = 0; prev_seq = 0; prev_to = 0; busy_chk = 0;
      end else begin
        if (busy_chk) begin chk("busy_low_after_done", 32'(busy), 32'd0); busy_chk = 0; end
        if (trigger) begin
          chk("trigger_single_cycle", 32'(prev_trig), 32'd0);
          trig_cyc = cyc;
          n_trig++;
        end
        if (req_drop) n_drop_obs++;
        if (done_pulse) begin
          chk("done_expected", 32'(q_done.size() != 0), 32'd1);
          if (q_done.size() != 0) begin
            d = q_done.pop_front();
            chk("done_cnt", 32'(done_cnt), 32'(d.cnt));
            chk("done_latency", 32'(cyc - trig_cyc), 32'(d.lat));
            if (d.gap != 0) chk("done_spacing", 32'(cyc - last_done), 32'(d.gap));
          end
          last_done = cyc;
          busy_chk = 1;
        end
        if ((err_seq && !prev_seq) || (err_timeout && !prev_to)) begin
          chk("err_expected", 32'(q_err.size() != 0), 32'd1);
          if (q_err.size() != 0) begin
            e = q_err.pop_front();
            chk("err_kind", (err_seq && !prev_seq) ? 32'd1 : 32'd2, 32'(e.kind));
            chk("err_latency", 32'(cyc - trig_cyc), 32'(e.lat));
          end
          chk("busy_low_on_abort", 32'(busy), 32'd0);
        end
        prev_trig = trigger; prev_seq = err_seq; prev_to = err_timeout;
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int k;
    int base;
    int n_wrap;
    rst = 1'b0; start_req = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({trigger, busy, pend_cnt, req_drop, done_pulse,
                              done_cnt, err_seq, err_timeout}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // single nominal transaction
    push_done(4, 0);
    pulse(1);
    chk("pend_after_req", 32'(pend_cnt), 32'd1);
    wait_idle(50);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_no_errors", 32'({err_seq, err_timeout}), 32'd0);

    // five back-to-back requests: saturation, one drop, 6-cycle spacing
    push_done(4, 0);
    repeat (3) push_done(4, 6);
    exp_drop++;
    pulse(5);
    chk("pend_saturated", 32'(pend_cnt), 32'd3);
    chk("req_drop_pulse", 32'(req_drop), 32'd1);
    wait_idle(100);
    chk("t2_done_cnt", 32'(done_cnt), 32'd5);

    // WAIT stretched by two cycles
    wait_extra = 2;
    push_done(6, 0);
    pulse(1);
    wait_idle(50);
    wait_extra = 0;
    chk("stall_no_errors", 32'({err_seq, err_timeout}), 32'd0);

    // WAIT held past the watchdog limit
    wait_extra = 10;
    push_err(2, TIMEOUT);
    pulse(1);
    wait_idle(60);
    wait_extra = 0;
    chk("timeout_flag", 32'(err_timeout), 32'd1);
    chk("timeout_cnt_kept", 32'(done_cnt), 32'(exp_cnt));
    clr_pulse();
    chk("timeout_cleared", 32'(err_timeout), 32'd0);

    // RUN jumps to DONE; second queued request still completes
    jump_once = 1'b1;
    push_err(1, 3);
    push_done(4, 0);
    pulse(2);
    k = 0;
    while (!err_seq && k < 20) begin @(negedge clk); k++; end
    chk("seq_err_seen", 32'(err_seq), 32'd1);
    clr_pulse();
    chk("seq_err_cleared", 32'(err_seq), 32'd0);
    wait_idle(50);
    chk("t4_done_cnt", 32'(done_cnt), 32'(exp_cnt));

    // run the completion counter around its wrap point
    n_wrap = 256 - int'(exp_cnt);
    for (int i = 0; i < n_wrap; i++) begin
      push_done(4, 0);
      pulse(1);
      wait_idle(30);
    end
    chk("wrap_done_cnt", 32'(done_cnt), 32'd0);

    // asynchronous reset mid-WAIT with two queued requests
    wait_extra = 5;
    pulse(3);
    k = 0;
    while (sm_state != 2'd2 && k < 20) begin @(negedge clk); k++; end
    chk("pre_reset_pend", 32'(pend_cnt), 32'd2);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", 32'({trigger, busy, pend_cnt, req_drop, done_pulse,
                                      done_cnt, err_seq, err_timeout}), 32'd0);
    exp_cnt = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_extra = 0;
    base = n_trig;
    repeat (20) @(negedge clk);
    chk("no_trigger_after_reset", 32'(n_trig - base), 32'd0);
    chk("pend_after_reset", 32'(pend_cnt), 32'd0);
    push_done(4, 0);
    pulse(1);
    wait_idle(50);
    chk("post_reset_done_cnt", 32'(done_cnt), 32'd1);

    chk("done_queue_empty", 32'(q_done.size()), 32'd0);
    chk("err_queue_empty", 32'(q_err.size()), 32'd0);
    chk("drop_count", 32'(n_drop_obs), 32'(exp_drop));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
